pwm_duty_ctrl: RTL and testbench
================================

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 5000, giving the clk cycles per 10% duty step; PWM period = 10*STEP_CYCLES.
REQ-002 SHALL have parameter DEB_CYCLES, default 1_000_000, giving the consecutive stable cycles required to accept a button change.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_up_n  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk.
REQ-006 key_dn_n  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk.
REQ-007 pwm_out  output  1  PWM waveform, registered.
REQ-008 level  output  4  requested duty level 0..10 (duty = 10*level %).
REQ-009 digit0, digit1, digit2  output  4 each  display codes for the downstream 7-segment decoder; each equals level.
REQ-010 step_pulse  output  1  one-cycle strobe asserted when level changes.

Function
REQ-011 Each key SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debouncer SHALL change its debounced output only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear the stability counter.
REQ-013 A press event SHALL be one cycle of debounced state going released->pressed; release SHALL generate no event.
REQ-014 On an up event, level SHALL increment on the next clk edge, saturating at 10.
REQ-015 On a down event, level SHALL decrement on the next clk edge, saturating at 0.
REQ-016 Up and down events in the same cycle SHALL leave level unchanged and SHALL NOT assert step_pulse.
REQ-017 step_pulse SHALL be high for exactly the cycle in which the new level value first appears; no pulse at saturation.
REQ-018 digit0/1/2 SHALL track level with zero additional latency (combinational copy or same register).
REQ-019 A period counter SHALL count 0..10*STEP_CYCLES-1 and wrap to 0.
REQ-020 An active-level shadow register SHALL load level only in the cycle the period counter wraps to 0.
REQ-021 pwm_out SHALL be high when period counter < active_level*STEP_CYCLES, registered (one cycle after the compare).
REQ-022 active_level 0 SHALL give pwm_out constantly low; 10 SHALL give constantly high, with no glitch at wrap.
REQ-023 A level change mid-period SHALL NOT alter the current period's waveform.
REQ-024 Counter widths SHALL be derived from parameters with $clog2; multiply SHALL be sized to avoid truncation.

Reset
REQ-025 While rst_n=0: level=0, active level=0, pwm_out=0, step_pulse=0, digits=0, period counter=0, debounced states=released, synchronizer flops=1, stability counters=0.
REQ-026 Reset assertion mid-period or mid-debounce SHALL abort immediately; after release the first period SHALL start at counter 0.
REQ-027 A button held through reset deassertion SHALL generate one press event after DEB_CYCLES stable cycles.

Structure
REQ-028 LEVEL_MAX (10) and LEVEL_W (4) SHALL live in the shared project package, used also by the display decoder.
REQ-029 Debounce+sync+edge detect SHALL be one sub-module, key_debounce, instantiated twice.

Verification (STEP_CYCLES=4, DEB_CYCLES=8)
REQ-030 Reset, hold key_up_n low 20 cycles -> level 0->1 once, step_pulse one cycle, digits=1; after next wrap pwm_out high 4 of 40 cycles.
REQ-031 Bounce key_up_n low/high every 3 cycles for 30 cycles, then release -> level unchanged, no step_pulse.
REQ-032 12 clean up presses from 0 -> level saturates at 10, 10 step_pulses, pwm_out constantly high; 12 down presses -> 0, pwm_out constantly low.
REQ-033 Both keys pressed simultaneously (identical edges) at level 5 -> level stays 5, no step_pulse.
REQ-034 Level 3->7 at counter 10 -> remainder of the period keeps 12 high cycles; next period 28 high cycles.
REQ-035 rst_n pulsed low mid-period at level 6 -> all outputs 0 asynchronously; pwm_out stays low after release.

Source files
------------

// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared project definitions for the PWM duty controller and the display decoder:
// duty level range plus the level-update rule used by the controller.
package pwm_duty_ctrl_pkg;

  localparam int LEVEL_MAX = 10;
  localparam int LEVEL_W   = 4;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    CMD_HOLD,
    CMD_UP,
    CMD_DOWN
  } level_cmd_e;

  // Simultaneous up and down presses cancel each other.
  function automatic level_cmd_e decode_cmd(input logic up, input logic dn);
    level_cmd_e cmd;
    case ({up, dn})
      2'b10:   cmd = CMD_UP;
      2'b01:   cmd = CMD_DOWN;
      default: cmd = CMD_HOLD;
    endcase
    return cmd;
  endfunction

  function automatic level_t apply_cmd(input level_t lvl, input level_cmd_e cmd);
    level_t nxt;
    nxt = lvl;
    case (cmd)
      CMD_UP:   if (lvl < level_t'(LEVEL_MAX)) nxt = lvl + 1'b1;
      CMD_DOWN: if (lvl != '0) nxt = lvl - 1'b1;
      default:  nxt = lvl;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Pin bundle of the PWM duty controller: raw push-buttons in, PWM and display codes out.
interface pwm_duty_ctrl_if;
  import pwm_duty_ctrl_pkg::*;

  logic   key_up_n;
  logic   key_dn_n;
  logic   pwm_out;
  level_t level;
  level_t digit0;
  level_t digit1;
  level_t digit2;
  logic   step_pulse;

  modport master (
    output key_up_n, key_dn_n,
    input  pwm_out, level, digit0, digit1, digit2, step_pulse
  );

  modport slave (
    input  key_up_n, key_dn_n,
    output pwm_out, level, digit0, digit1, digit2, step_pulse
  );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes one active-low push-button, debounces it and emits a one-cycle
// strobe when the debounced state goes from released to pressed.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    deb_d   = deb_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        deb_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Push-button duty controller: up/down keys step a 0..10 level, a period counter
// drives a registered PWM whose duty is latched only at period boundaries.
module pwm_duty_ctrl
  import pwm_duty_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = 5000,
  parameter int DEB_CYCLES  = 1_000_000
) (
  input logic           clk,
  input logic           rst_n,
  pwm_duty_ctrl_if.slave bus
);

  localparam int PERIOD = LEVEL_MAX * STEP_CYCLES;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int THR_W  = $clog2(PERIOD + 1);

  logic             up_press, dn_press;
  level_cmd_e       cmd;
  level_t           level_q, level_d;
  level_t           active_q, active_d;
  logic             step_q, step_d;
  logic             pwm_q, pwm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [THR_W-1:0] threshold;
  logic             wrap;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (bus.key_up_n),
    .press_o (up_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_dn (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (bus.key_dn_n),
    .press_o (dn_press)
  );

  always_comb begin
    cmd     = decode_cmd(up_press, dn_press);
    level_d = apply_cmd(level_q, cmd);
    step_d  = (level_d != level_q);
  end

  // The shadow level changes only at the wrap, so a mid-period request never
  // reshapes the waveform already in progress.
  always_comb begin
    wrap      = (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    active_d  = wrap ? level_q : active_q;
    threshold = THR_W'(active_q) * THR_W'(STEP_CYCLES);
    pwm_d     = (THR_W'(cnt_q) < threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      step_q   <= 1'b0;
      active_q <= '0;
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      step_q   <= step_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
    end
  end

  assign bus.level      = level_q;
  assign bus.digit0     = level_q;
  assign bus.digit1     = level_q;
  assign bus.digit2     = level_q;
  assign bus.step_pulse = step_q;
  assign bus.pwm_out    = pwm_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl with STEP_CYCLES=4, DEB_CYCLES=8: directed
// scenarios plus random key activity compared against a behavioural reference.
module tb_pwm_duty_ctrl;

  localparam int STEP   = 4;
  localparam int DEB    = 8;
  localparam int LMAX   = 10;
  localparam int PERIOD = LMAX * STEP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pwm_duty_ctrl_if bus_if ();

  pwm_duty_ctrl #(.STEP_CYCLES(STEP), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: a key is accepted once its synchronized samples (two cycles old)
  // have all disagreed with the accepted state for the last DEB cycles.
  logic [DEB:0] up_hist_m, dn_hist_m;
  logic         up_deb_m, dn_deb_m, up_ev_m, dn_ev_m, step_m, pwm_m;
  int           level_m, active_m, cnt_m;

  wire up_press_m = up_deb_m && (up_hist_m[DEB:1] == '0);
  wire up_rel_m   = !up_deb_m && (&up_hist_m[DEB:1]);
  wire dn_press_m = dn_deb_m && (dn_hist_m[DEB:1] == '0);
  wire dn_rel_m   = !dn_deb_m && (&dn_hist_m[DEB:1]);

  function automatic int next_level_m(input int l, input logic u, input logic d);
    if (u && !d) return (l < LMAX) ? l + 1 : l;
    if (d && !u) return (l > 0) ? l - 1 : l;
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_hist_m <= '1;
      dn_hist_m <= '1;
      up_deb_m  <= 1'b1;
      dn_deb_m  <= 1'b1;
      up_ev_m   <= 1'b0;
      dn_ev_m   <= 1'b0;
      level_m   <= 0;
      active_m  <= 0;
      cnt_m     <= 0;
      step_m    <= 1'b0;
      pwm_m     <= 1'b0;
    end else begin
      up_hist_m <= {up_hist_m[DEB-1:0], bus_if.key_up_n};
      dn_hist_m <= {dn_hist_m[DEB-1:0], bus_if.key_dn_n};
      up_deb_m  <= up_press_m ? 1'b0 : (up_rel_m ? 1'b1 : up_deb_m);
      dn_deb_m  <= dn_press_m ? 1'b0 : (dn_rel_m ? 1'b1 : dn_deb_m);
      up_ev_m   <= up_press_m;
      dn_ev_m   <= dn_press_m;
      level_m   <= next_level_m(level_m, up_ev_m, dn_ev_m);
      step_m    <= (next_level_m(level_m, up_ev_m, dn_ev_m) != level_m);
      pwm_m     <= (cnt_m < active_m * STEP);
      if (cnt_m == PERIOD - 1) begin
        cnt_m    <= 0;
        active_m <= level_m;
      end else begin
        cnt_m <= cnt_m + 1;
      end
    end
  end

  int step_dut_cnt = 0;
  int step_ref_cnt = 0;

  always @(posedge clk) begin
    if (rst_n && bus_if.step_pulse === 1'b1) step_dut_cnt <= step_dut_cnt + 1;
    if (rst_n && step_m) step_ref_cnt <= step_ref_cnt + 1;
  end

  task automatic drive(input logic up_n, input logic dn_n, input int cycles);
    bus_if.key_up_n = up_n;
    bus_if.key_dn_n = dn_n;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 3);
    checks++; if (bus_if.level !== 4'd0)    begin errors++; $display("FAIL reset_level got=%0d exp=0", bus_if.level); end
    checks++; if (bus_if.pwm_out !== 1'b0)  begin errors++; $display("FAIL reset_pwm got=%b exp=0", bus_if.pwm_out); end
    checks++; if (bus_if.step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step got=%b exp=0", bus_if.step_pulse); end
    checks++; if (bus_if.digit0 !== 4'd0)   begin errors++; $display("FAIL reset_digit0 got=%0d exp=0", bus_if.digit0); end
    checks++; if (bus_if.digit1 !== 4'd0)   begin errors++; $display("FAIL reset_digit1 got=%0d exp=0", bus_if.digit1); end
    checks++; if (bus_if.digit2 !== 4'd0)   begin errors++; $display("FAIL reset_digit2 got=%0d exp=0", bus_if.digit2); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_press();
    int s0, highs;
    s0 = step_dut_cnt;
    drive(1'b0, 1'b1, 20);
    checks++; if (bus_if.level !== 4'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", bus_if.level); end
    checks++; if (bus_if.level !== level_m[3:0]) begin errors++; $display("FAIL single_level_model got=%0d exp=%0d", bus_if.level, level_m); end
    checks++; if ({bus_if.digit0, bus_if.digit1, bus_if.digit2} !== {3{4'd1}})
      begin errors++; $display("FAIL single_digits got=%0d/%0d/%0d exp=1", bus_if.digit0, bus_if.digit1, bus_if.digit2); end
    checks++; if (step_dut_cnt - s0 != 1) begin errors++; $display("FAIL single_step_count got=%0d exp=1", step_dut_cnt - s0); end
    drive(1'b1, 1'b1, 20 + PERIOD);
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (bus_if.pwm_out === 1'b1) highs++;
      checks++; if (bus_if.pwm_out !== pwm_m) begin errors++; $display("FAIL single_pwm_cycle got=%b exp=%b", bus_if.pwm_out, pwm_m); end
      @(negedge clk);
    end
    checks++; if (highs != STEP) begin errors++; $display("FAIL single_pwm_highs got=%0d exp=%0d", highs, STEP); end
  endtask

  task automatic test_bounce();
    int s0;
    s0 = step_dut_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 3);
      drive(1'b1, 1'b1, 3);
    end
    drive(1'b1, 1'b1, 20);
    checks++; if (bus_if.level !== 4'd1) begin errors++; $display("FAIL bounce_level got=%0d exp=1", bus_if.level); end
    checks++; if (step_dut_cnt != s0) begin errors++; $display("FAIL bounce_step_count got=%0d exp=0", step_dut_cnt - s0); end
  endtask

  task automatic test_saturate();
    int s0;
    drive(1'b1, 1'b0, 14);
    drive(1'b1, 1'b1, 14);
    checks++; if (bus_if.level !== 4'd0) begin errors++; $display("FAIL sat_start_level got=%0d exp=0", bus_if.level); end
    s0 = step_dut_cnt;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 14);
      drive(1'b1, 1'b1, 14);
    end
    checks++; if (bus_if.level !== 4'd10) begin errors++; $display("FAIL sat_up_level got=%0d exp=10", bus_if.level); end
    checks++; if (step_dut_cnt - s0 != 10) begin errors++; $display("FAIL sat_up_steps got=%0d exp=10", step_dut_cnt - s0); end
    drive(1'b1, 1'b1, PERIOD + 2);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      checks++; if (bus_if.pwm_out !== 1'b1) begin errors++; $display("FAIL sat_pwm_high cycle=%0d got=%b exp=1", i, bus_if.pwm_out); end
      @(negedge clk);
    end
    s0 = step_dut_cnt;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 14);
      drive(1'b1, 1'b1, 14);
    end
    checks++; if (bus_if.level !== 4'd0) begin errors++; $display("FAIL sat_dn_level got=%0d exp=0", bus_if.level); end
    checks++; if (step_dut_cnt - s0 != 10) begin errors++; $display("FAIL sat_dn_steps got=%0d exp=10", step_dut_cnt - s0); end
    drive(1'b1, 1'b1, PERIOD + 2);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      checks++; if (bus_if.pwm_out !== 1'b0) begin errors++; $display("FAIL sat_pwm_low cycle=%0d got=%b exp=0", i, bus_if.pwm_out); end
      @(negedge clk);
    end
  endtask

  task automatic test_both_keys();
    int s0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 14);
      drive(1'b1, 1'b1, 14);
    end
    checks++; if (bus_if.level !== 4'd5) begin errors++; $display("FAIL both_pre_level got=%0d exp=5", bus_if.level); end
    s0 = step_dut_cnt;
    drive(1'b0, 1'b0, 20);
    drive(1'b1, 1'b1, 20);
    checks++; if (bus_if.level !== 4'd5) begin errors++; $display("FAIL both_level got=%0d exp=5", bus_if.level); end
    checks++; if (step_dut_cnt != s0) begin errors++; $display("FAIL both_step_count got=%0d exp=0", step_dut_cnt - s0); end
  endtask

  task automatic test_mid_period();
    int hi[4];
    int p;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 14);
      drive(1'b1, 1'b1, 14);
    end
    drive(1'b1, 1'b1, 2 * PERIOD);
    checks++; if (bus_if.level !== 4'd3) begin errors++; $display("FAIL mid_pre_level got=%0d exp=3", bus_if.level); end
    for (int i = 0; i < PERIOD && cnt_m != PERIOD - 1; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    // First press is timed so the new level appears with the counter at 10.
    for (int t = 0; t < 2 + 4 * PERIOD; t++) begin
      checks++; if (bus_if.pwm_out !== pwm_m) begin errors++; $display("FAIL mid_pwm_cycle t=%0d got=%b exp=%b", t, bus_if.pwm_out, pwm_m); end
      if (t >= 2) begin
        p = (t - 2) / PERIOD;
        if (bus_if.pwm_out === 1'b1) hi[p]++;
      end
      bus_if.key_up_n = !((t < 4 * 28) && ((t % 28) < 14));
      bus_if.key_dn_n = 1'b1;
      @(negedge clk);
    end
    checks++; if (hi[0] != 3 * STEP) begin errors++; $display("FAIL mid_period_keep got=%0d exp=%0d", hi[0], 3 * STEP); end
    checks++; if (hi[3] != 7 * STEP) begin errors++; $display("FAIL mid_next_period got=%0d exp=%0d", hi[3], 7 * STEP); end
    checks++; if (bus_if.level !== 4'd7) begin errors++; $display("FAIL mid_level got=%0d exp=7", bus_if.level); end
  endtask

  task automatic test_reset_mid_period();
    int s0;
    drive(1'b1, 1'b0, 14);
    drive(1'b1, 1'b1, 14 + 2 * PERIOD);
    checks++; if (bus_if.level !== 4'd6) begin errors++; $display("FAIL rst_pre_level got=%0d exp=6", bus_if.level); end
    for (int i = 0; i < PERIOD && cnt_m != 15; i++) @(negedge clk);
    checks++; if (bus_if.pwm_out !== 1'b1) begin errors++; $display("FAIL rst_pre_pwm got=%b exp=1", bus_if.pwm_out); end
    bus_if.key_up_n = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_if.pwm_out !== 1'b0) begin errors++; $display("FAIL rst_async_pwm got=%b exp=0", bus_if.pwm_out); end
    checks++; if (bus_if.level !== 4'd0) begin errors++; $display("FAIL rst_async_level got=%0d exp=0", bus_if.level); end
    checks++; if (bus_if.step_pulse !== 1'b0) begin errors++; $display("FAIL rst_async_step got=%b exp=0", bus_if.step_pulse); end
    checks++; if ({bus_if.digit0, bus_if.digit1, bus_if.digit2} !== 12'd0)
      begin errors++; $display("FAIL rst_async_digits got=%0d/%0d/%0d exp=0", bus_if.digit0, bus_if.digit1, bus_if.digit2); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = step_dut_cnt;
    for (int i = 0; i < PERIOD; i++) begin
      checks++; if (bus_if.pwm_out !== 1'b0) begin errors++; $display("FAIL rst_post_pwm cycle=%0d got=%b exp=0", i, bus_if.pwm_out); end
      @(negedge clk);
    end
    checks++; if (bus_if.level !== 4'd1) begin errors++; $display("FAIL rst_held_key_level got=%0d exp=1", bus_if.level); end
    checks++; if (step_dut_cnt - s0 != 1) begin errors++; $display("FAIL rst_held_key_steps got=%0d exp=1", step_dut_cnt - s0); end
    drive(1'b1, 1'b1, 20);
  endtask

  task automatic test_random();
    int   kind, hold, gap, len;
    logic up_n, dn_n;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 3);
      hold = (kind == 3) ? $urandom_range(2, 7) : $urandom_range(9, 16);
      gap  = $urandom_range(2, 16);
      up_n = (kind == 1);
      dn_n = !((kind == 1) || (kind == 2));
      for (int ph = 0; ph < 2; ph++) begin
        bus_if.key_up_n = (ph == 1) ? 1'b1 : up_n;
        bus_if.key_dn_n = (ph == 1) ? 1'b1 : dn_n;
        len = (ph == 1) ? gap : hold;
        for (int c = 0; c < len; c++) begin
          @(negedge clk);
          checks++; if (bus_if.level !== level_m[3:0]) begin errors++; $display("FAIL rand_level it=%0d got=%0d exp=%0d", it, bus_if.level, level_m); end
          checks++; if (bus_if.step_pulse !== step_m) begin errors++; $display("FAIL rand_step it=%0d got=%b exp=%b", it, bus_if.step_pulse, step_m); end
          checks++; if (bus_if.pwm_out !== pwm_m) begin errors++; $display("FAIL rand_pwm it=%0d got=%b exp=%b", it, bus_if.pwm_out, pwm_m); end
        end
      end
    end
    drive(1'b1, 1'b1, 20);
    checks++; if (step_dut_cnt != step_ref_cnt) begin errors++; $display("FAIL rand_step_total got=%0d exp=%0d", step_dut_cnt, step_ref_cnt); end
  endtask

  initial begin
    bus_if.key_up_n = 1'b1;
    bus_if.key_dn_n = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_saturate();
    test_both_keys();
    test_mid_period();
    test_reset_mid_period();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
